s_mem_arbiter: RTL and testbench
================================

S_MEM_ARBITER -- requirements
Module: s_mem_arbiter

Interface
REQ-001 Parameter READ_LAT, default 1, clocks from RAM address presentation to valid mem_q; legal values 1 or 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  3  per-requester access request; bit 0 = fill FSM, bit 1 = KSA swap FSM, bit 2 = PRGA/decrypt FSM.
REQ-005 we  input  3  per-requester write enable; only meaningful while that requester is granted.
REQ-006 addr  input  24  packed addresses; requester n uses bits [8n+7:8n].
REQ-007 wdata  input  24  packed write data; same packing as addr.
REQ-008 gnt  output  3  one-hot registered grant; all zero when idle.
REQ-009 rdata  output  8  read data, valid only in cycles where any rvalid bit is high.
REQ-010 rvalid  output  3  one-cycle pulse to the requester that issued the read.
REQ-011 mem_address, mem_data  output  8 each  to the shared 256x8 s_memory port.
REQ-012 mem_wren  output  1  s_memory write enable.
REQ-013 mem_q  input  8  s_memory read data.
REQ-014 busy  output  1  high whenever gnt is non-zero.

Function
REQ-015 FSM states: IDLE, GRANTED; the current owner index is held in a 2-bit register.
REQ-016 IDLE: if any req bit is high at edge t, the arbiter enters GRANTED at t+1 with gnt set to the selected requester.
REQ-017 GRANTED: the grant is locked while req[owner] stays high, so a multi-cycle read-modify-write swap cannot be interleaved.
REQ-018 GRANTED: if req[owner] is low at an edge, the next state is IDLE with gnt=0, giving one dead cycle before any new grant.
REQ-019 While GRANTED, mem_address, mem_data and mem_wren are combinational muxes of the owner's addr, wdata and we.
REQ-020 While IDLE, mem_wren=0, mem_address=0 and mem_data=0.
REQ-021 A non-granted requester's we never reaches mem_wren.
REQ-022 Read pipeline: a granted cycle with we[owner]=0 pushes the owner tag into a READ_LAT-deep shift pipeline.
REQ-023 The matching rvalid bit pulses exactly READ_LAT cycles after the read cycle, with rdata=mem_q.
REQ-024 Writes generate no rvalid.
REQ-025 Back-to-back reads by the owner produce back-to-back rvalid pulses, one per read, in issue order.
REQ-026 Pending rvalid pulses are still delivered after the owner releases, and are tagged to the original issuer even if a new grant has begun.
REQ-027 A requester that raises and drops req in the same IDLE cycle is still granted for one cycle; requesters hold req until they see gnt.
REQ-028 At most one gnt bit is ever high.
REQ-029 rvalid is at most one-hot.

Reset
REQ-030 On reset: state=IDLE, gnt=0, rvalid=0, read pipeline cleared, busy=0, and the round-robin pointer last_owner=2.
REQ-031 A reset asserted mid-grant or with reads in flight drops the grant and discards in-flight rvalid on the next edge.
REQ-032 With reset high, mem_wren=0 on the next edge.

Configuration
REQ-033 With S_ARB_ROUND_ROBIN_EN defined, arbitration in IDLE is round-robin: search order begins at (last_owner+1) mod 3, and last_owner updates on each new grant.
REQ-034 Without S_ARB_ROUND_ROBIN_EN, arbitration is fixed priority: req[0] > req[1] > req[2], and no pointer register is built.

Verification
REQ-035 Setup: reset for 2 cycles, then req=3'b010, we=0, addr[15:8]=8'h2A, mem_q model returns 8'h55.
  Required: gnt=3'b010 one cycle later, and rvalid=3'b010 with rdata=8'h55 READ_LAT cycles after the first granted cycle.
REQ-036 Setup: req=3'b111 from IDLE, with each requester holding for 3 cycles then dropping.
  Required, fixed priority: grant order 0,1,2.
  Required, round-robin after reset: grant order 0,1,2, then with all still requesting, the next grant after owner 2 goes to 0.
  Required in both modes: one idle cycle between grants.
REQ-037 Setup: owner 1 performs read s[i], read s[j], write s[j], write s[i] while req[0] and req[2] stay high.
  Required: no gnt change until req[1] drops; mem_wren high only in the owner's two write cycles.
REQ-038 Setup: requester 2 is ungranted with we[2]=1 and addr[23:16]=8'hFF.
  Required: mem_wren stays 0 and mem_address never equals 8'hFF from that requester.
REQ-039 Setup: owner 0 issues a read in its last granted cycle, then requester 1 is granted.
  Required: rvalid=3'b001 still arrives READ_LAT cycles after the read, and rvalid[1] stays 0.
REQ-040 Setup: reset asserted mid-grant with two reads in flight.
  Required: the next cycle shows gnt=0, rvalid=0 and mem_wren=0, and no stale rvalid appears afterwards.

Source files
------------

// File: rtl/s_mem_arbiter_if.sv
// Bundle between the three S-memory requesters, the arbiter and the shared 256x8 RAM port.
// The arbiter takes the slave side; the requesters and the RAM model drive the master side.
interface s_mem_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [23:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [7:0]  rdata;
  logic [2:0]  rvalid;
  logic        busy;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q;

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output gnt, rdata, rvalid, busy, mem_address, mem_data, mem_wren
  );

  modport master (
    output req, we, addr, wdata, mem_q,
    input  gnt, rdata, rvalid, busy, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/s_mem_arbiter.sv
// Three-way arbiter for the single S-memory port with a tagged read-return pipeline.
// Define S_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (0 > 1 > 2) otherwise.
module s_mem_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  s_mem_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] GRANTED = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [2:0] gnt_q, gnt_d;

  logic       sel_vld;
  logic [1:0] sel_idx;

  logic [7:0] own_addr, own_wdata;
  logic       own_we;
  logic       rd_push;

  logic [READ_LAT:1]       vld_pipe_q, vld_pipe_d;
  logic [READ_LAT:1][1:0]  tag_pipe_q, tag_pipe_d;

  always_comb begin
    own_addr  = bus.addr[7:0];
    own_wdata = bus.wdata[7:0];
    own_we    = bus.we[0];
    case (owner_q)
      2'd1: begin
        own_addr  = bus.addr[15:8];
        own_wdata = bus.wdata[15:8];
        own_we    = bus.we[1];
      end
      2'd2: begin
        own_addr  = bus.addr[23:16];
        own_wdata = bus.wdata[23:16];
        own_we    = bus.we[2];
      end
      default: ;
    endcase
  end

`ifdef S_ARB_ROUND_ROBIN_EN
  logic [1:0] last_owner_q, last_owner_d;
  logic [1:0] rr_start, rr_cand;

  function automatic logic [1:0] rr_idx(input logic [1:0] start, input logic [1:0] ofs);
    logic [2:0] s;
    s = {1'b0, start} + {1'b0, ofs};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Walk from lowest to highest precedence so the nearest requester after last_owner wins.
  always_comb begin
    rr_start = (last_owner_q == 2'd2) ? 2'd0 : last_owner_q + 2'd1;
    sel_vld  = 1'b0;
    sel_idx  = 2'd0;
    rr_cand  = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      rr_cand = rr_idx(rr_start, 2'(i));
      if (bus.req[rr_cand]) begin
        sel_vld = 1'b1;
        sel_idx = rr_cand;
      end
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && sel_vld) last_owner_d = sel_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) last_owner_q <= 2'd2;
    else       last_owner_q <= last_owner_d;
  end
`else
  always_comb begin
    sel_vld = |bus.req;
    sel_idx = 2'd2;
    if (bus.req[1]) sel_idx = 2'd1;
    if (bus.req[0]) sel_idx = 2'd0;
  end
`endif

  // Grant stays locked while the owner holds req so read-modify-write swaps are atomic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = GRANTED;
          owner_d = sel_idx;
          gnt_d   = 3'b001 << sel_idx;
        end
      end
      GRANTED: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // Every granted non-write cycle is a read; its tag rides along to the RAM's return cycle.
  assign rd_push = (state_q == GRANTED) && !own_we;

  always_comb begin
    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[1] = rd_push;
    tag_pipe_d[1] = owner_q;
    for (int k = 2; k <= READ_LAT; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      tag_pipe_d[k] = tag_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      gnt_q      <= 3'b000;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.busy        = |gnt_q;
  assign bus.mem_wren    = (state_q == GRANTED) && own_we;
  assign bus.mem_address = (state_q == GRANTED) ? own_addr  : 8'd0;
  assign bus.mem_data    = (state_q == GRANTED) ? own_wdata : 8'd0;
  assign bus.rvalid      = vld_pipe_q[READ_LAT] ? (3'b001 << tag_pipe_q[READ_LAT]) : 3'b000;
  assign bus.rdata       = bus.mem_q;

  a_gnt_onehot:    assert property (@(posedge clk) disable iff (reset) $onehot0(bus.gnt));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.rvalid));

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed bench for s_mem_arbiter: a spec-level grant/read-return model checked every cycle,
// plus literal checkpoints for the canonical scenarios.
module tb_s_mem_arbiter;
  parameter int READ_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  s_mem_arbiter_if bus();
  s_mem_arbiter #(.READ_LAT(READ_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return (i == 42) ? 8'h55 : 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] byte_of(input logic [23:0] v, input int n);
    case (n)
      1:       return v[15:8];
      2:       return v[23:16];
      default: return v[7:0];
    endcase
  endfunction

  // RAM model: read-first, data appears READ_LAT cycles after the address cycle
  logic [7:0] ram [256];
  logic [7:0] q_pipe [1:2];
  bit init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      init_done <= 1'b1;
    end else begin
      q_pipe[1] <= ram[bus.mem_address];
      if (bus.mem_wren === 1'b1) ram[bus.mem_address] <= bus.mem_data;
    end
    q_pipe[2] <= q_pipe[1];
  end
  assign bus.mem_q = q_pipe[READ_LAT];

  // Behavioural model: owner as an int (-1 idle), reads as a queue of due-cycle events
  typedef struct { int due; int tag; logic [7:0] data; } rd_t;
  rd_t        pend[$];
  logic [7:0] shadow [256];
  int  m_owner = -1;
  int  m_last  = 2;
  int  cyc     = 0;
  bit  armed   = 1'b0;
  bit  m_init  = 1'b0;

  always @(negedge clk) begin
    logic [2:0] eg, erv;
    logic [7:0] ea, ed, erd;
    logic       ew;
    if (!m_init) begin
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      m_init = 1'b1;
    end
    if (armed) begin
      eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      ew = 1'b0; ea = 8'd0; ed = 8'd0;
      if (m_owner >= 0) begin
        ew = bus.we[2'(m_owner)];
        ea = byte_of(bus.addr, m_owner);
        ed = byte_of(bus.wdata, m_owner);
      end
      erv = 3'b000; erd = 8'd0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        erv = 3'(1 << pend[0].tag);
        erd = pend[0].data;
        void'(pend.pop_front());
      end
      chk("gnt",         32'(bus.gnt),         32'(eg));
      chk("busy",        32'(bus.busy),        32'(eg != 3'b000));
      chk("mem_wren",    32'(bus.mem_wren),    32'(ew));
      chk("mem_address", 32'(bus.mem_address), 32'(ea));
      chk("mem_data",    32'(bus.mem_data),    32'(ed));
      chk("rvalid",      32'(bus.rvalid),      32'(erv));
      if (erv != 3'b000) chk("rdata", 32'(bus.rdata), 32'(erd));
      if (m_owner >= 0) begin
        if (ew) shadow[ea] = ed;
        else    pend.push_back('{cyc + READ_LAT, m_owner, shadow[ea]});
        if (!bus.req[2'(m_owner)]) m_owner = -1;
      end else if (bus.req != 3'b000) begin
`ifdef S_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++)
          if (m_owner < 0 && bus.req[2'((m_last + k) % 3)]) m_owner = (m_last + k) % 3;
        m_last = m_owner;
`else
        for (int k = 2; k >= 0; k--)
          if (bus.req[2'(k)]) m_owner = k;
`endif
      end
    end
    if (reset) begin
      m_owner = -1;
      m_last  = 2;
      pend.delete();
      armed   = 1'b1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] w,
                      input logic [23:0] a, input logic [23:0] d);
    tick();
    bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d;
  endtask

  logic [2:0] t2_req [14] = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110, 3'b100,
                              3'b100, 3'b101, 3'b101, 3'b001, 3'b001, 3'b000, 3'b000};
  logic [2:0] t2_gnt [14] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010,
                              3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001, 3'b000};

  logic [2:0] t3_req  [5] = '{3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
  logic [2:0] t3_we   [5] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b000};
  logic [7:0] t3_a1   [5] = '{8'h10, 8'h20, 8'h20, 8'h10, 8'h10};
  logic [7:0] t3_d1   [5] = '{8'h00, 8'h00, 8'hC3, 8'h3C, 8'h00};
  logic [2:0] t3_gnt  [5] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
  logic       t3_wren [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    bus.req = 3'b000; bus.we = 3'b000; bus.addr = 24'd0; bus.wdata = 24'd0;
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt",    32'(bus.gnt),      32'd0);
    chk("rst_busy",   32'(bus.busy),     32'd0);
    chk("rst_rvalid", 32'(bus.rvalid),   32'd0);
    chk("rst_wren",   32'(bus.mem_wren), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // single read by requester 1
    step(3'b010, 3'b000, 24'h002A00, 24'd0);
    step(3'b000, 3'b000, 24'h002A00, 24'd0);
    @(negedge clk);
    chk("t1_gnt",  32'(bus.gnt),         32'h2);
    chk("t1_addr", 32'(bus.mem_address), 32'h2A);
    repeat (READ_LAT) @(negedge clk);
    chk("t1_rvalid", 32'(bus.rvalid), 32'h2);
    chk("t1_rdata",  32'(bus.rdata),  32'h55);
    step(3'b000, 3'b000, 24'd0, 24'd0);
    step(3'b000, 3'b000, 24'd0, 24'd0);

    // all three requesting, each holding for three granted cycles
    step(3'b111, 3'b000, 24'h302010, 24'd0);
    for (int c = 0; c < 14; c++) begin
      step(t2_req[c], 3'b000, 24'h302010, 24'd0);
      @(negedge clk);
      chk($sformatf("t2_gnt_c%0d", c + 1), 32'(bus.gnt), 32'(t2_gnt[c]));
    end
    step(3'b000, 3'b000, 24'd0, 24'd0);

    // locked read-read-write-write swap by owner 1 while 0 and 2 wait
    step(3'b010, 3'b000, 24'h501040, 24'd0);
    for (int c = 0; c < 5; c++) begin
      step(t3_req[c], t3_we[c], {8'h50, t3_a1[c], 8'h40}, {8'h00, t3_d1[c], 8'h00});
      @(negedge clk);
      chk($sformatf("t3_gnt_c%0d", c + 1),  32'(bus.gnt),      32'(t3_gnt[c]));
      chk($sformatf("t3_wren_c%0d", c + 1), 32'(bus.mem_wren), 32'(t3_wren[c]));
      if (t3_wren[c]) chk("t3_wdata", 32'(bus.mem_data), 32'(t3_d1[c]));
    end
    step(3'b000, 3'b000, 24'd0, 24'd0);
    step(3'b000, 3'b000, 24'd0, 24'd0);
    step(3'b000, 3'b000, 24'd0, 24'd0);

    // ungranted requester 2 holding we with address FF
    for (int c = 0; c < 5; c++) begin
      step((c < 3) ? 3'b001 : 3'b000, 3'b100, 24'hFF0005, 24'hAA0000);
      @(negedge clk);
      chk("t4_wren",   32'(bus.mem_wren),             32'd0);
      chk("t4_addrFF", 32'(bus.mem_address == 8'hFF), 32'd0);
    end
    step(3'b000, 3'b000, 24'd0, 24'd0);
    step(3'b000, 3'b000, 24'd0, 24'd0);

    // owner 0 reads in its final granted cycle, requester 1 (writing) follows
    step(3'b001, 3'b010, 24'h007733, 24'h009900);
    step(3'b010, 3'b010, 24'h007733, 24'h009900);
    @(negedge clk);
    chk("t5_gnt", 32'(bus.gnt), 32'h1);
    repeat (READ_LAT) @(negedge clk);
    chk("t5_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t5_rdata",  32'(bus.rdata),  32'h68);
    for (int c = 0; c < 4; c++) begin
      step(3'b010, 3'b010, 24'h007733, 24'h009900);
      @(negedge clk);
      chk("t5_rv1", 32'(bus.rvalid[1]), 32'd0);
    end
    step(3'b000, 3'b000, 24'd0, 24'd0);
    step(3'b000, 3'b000, 24'd0, 24'd0);
    step(3'b000, 3'b000, 24'd0, 24'd0);

    // reset mid-grant with reads in flight
    step(3'b100, 3'b000, 24'h440000, 24'd0);
    step(3'b100, 3'b000, 24'h440000, 24'd0);
    tick();
    reset = 1'b1;
    bus.addr = 24'h450000;
    tick();
    reset = 1'b0;
    bus.we = 3'b100;
    @(negedge clk);
    chk("t6_gnt",    32'(bus.gnt),      32'd0);
    chk("t6_rvalid", 32'(bus.rvalid),   32'd0);
    chk("t6_wren",   32'(bus.mem_wren), 32'd0);
    step(3'b100, 3'b100, 24'h460000, 24'h120000);
    repeat (READ_LAT + 3) step(3'b000, 3'b000, 24'd0, 24'd0);

    // mixed traffic pattern, checked by the model only
    for (int i = 0; i < 40; i++)
      step(3'((i * 3 + 1) % 8), 3'((i * 5) % 8),
           {8'(i * 3), 8'(i * 11), 8'(i * 7)}, {8'(i + 1), 8'(i + 2), 8'(i + 3)});
    repeat (READ_LAT + 4) step(3'b000, 3'b000, 24'd0, 24'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
